dm_mmio_responder: RTL



---
 rtl/dm_mmio_pkg.sv | 33 +++
 rtl/dm_mmio_responder_regfile.sv | 109 ++++++++++
 rtl/dm_mmio_responder.sv | 80 ++++++++
 3 files changed

// File: rtl/dm_mmio_pkg.sv
// Shared constants and the MMIO address decoder for the dual-port data-memory responder.
package dm_mmio_pkg;

    localparam int MMIO_BASE_BIT = 8;

    localparam logic [8:0] MMIO_SW   = 9'h100;
    localparam logic [8:0] MMIO_LEDR = 9'h101;
    localparam logic [8:0] MMIO_HEX  = 9'h102;
    localparam logic [8:0] MMIO_CYC  = 9'h103;
    localparam logic [8:0] MMIO_CONF = 9'h104;

    typedef enum logic [2:0] {
        REG_SW,
        REG_LEDR,
        REG_HEX,
        REG_CYC,
        REG_CONF,
        REG_NONE
    } reg_idx_e;

    // RAM addresses (bit 8 clear) never match a constant, so they decode to REG_NONE.
    function automatic reg_idx_e decode_reg(input logic [8:0] maddr);
        case (maddr)
            MMIO_SW:   return REG_SW;
            MMIO_LEDR: return REG_LEDR;
            MMIO_HEX:  return REG_HEX;
            MMIO_CYC:  return REG_CYC;
            MMIO_CONF: return REG_CONF;
            default:   return REG_NONE;
        endcase
    endfunction

endpackage

// File: rtl/dm_mmio_responder_regfile.sv
// MMIO register bank: LEDR/HEX storage, switch synchronizer, cycle and conflict counters,
// two write ports (p1 wins on same address) and two registered read ports.
module mmio_regfile
    import dm_mmio_pkg::*;
#(
    parameter int CYC_W = 16,
    parameter int SW_W  = 10,
    parameter int LED_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [8:0]       maddr0,
    input  logic [15:0]      wdata0,
    input  logic             write0,
    input  logic [8:0]       maddr1,
    input  logic [15:0]      wdata1,
    input  logic             write1,
    input  logic [SW_W-1:0]  sw_in,
    output logic [LED_W-1:0] ledr,
    output logic [15:0]      hex,
    output logic [15:0]      rd_data [2]
);

    logic [SW_W-1:0]  sw_meta_reg, sw_sync_reg;
    logic [LED_W-1:0] ledr_reg, ledr_next;
    logic [15:0]      hex_reg, hex_next;
    logic [CYC_W-1:0] cyc_reg;
    logic [15:0]      conf_reg, conf_next;
    logic             conflict, p0_write_eff, conf_clear;
    reg_idx_e         widx0, widx1;
    logic [8:0]       addr [2];

    assign addr[0] = maddr0;
    assign addr[1] = maddr1;
    assign widx0   = decode_reg(maddr0);
    assign widx1   = decode_reg(maddr1);

    always_comb begin
        conflict     = write0 & write1 & (maddr0 == maddr1);
        p0_write_eff = write0 & ~conflict;
        conf_clear   = (write0 && widx0 == REG_CONF) || (write1 && widx1 == REG_CONF);

        // p1 is applied last so it overrides p0 on a shared register
        ledr_next = ledr_reg;
        hex_next  = hex_reg;
        if (p0_write_eff && widx0 == REG_LEDR) ledr_next = wdata0[LED_W-1:0];
        if (p0_write_eff && widx0 == REG_HEX)  hex_next  = wdata0;
        if (write1 && widx1 == REG_LEDR)       ledr_next = wdata1[LED_W-1:0];
        if (write1 && widx1 == REG_HEX)        hex_next  = wdata1;

        conf_next = conf_reg;
        if (conf_clear)
            conf_next = '0;
        else if (conflict && conf_reg != 16'hFFFF)
            conf_next = conf_reg + 16'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sw_meta_reg <= '0;
            sw_sync_reg <= '0;
            ledr_reg    <= '0;
            hex_reg     <= '0;
            cyc_reg     <= '0;
            conf_reg    <= '0;
        end else begin
            sw_meta_reg <= sw_in;
            sw_sync_reg <= sw_meta_reg;
            ledr_reg    <= ledr_next;
            hex_reg     <= hex_next;
            cyc_reg     <= cyc_reg + 1'b1;
            conf_reg    <= conf_next;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_rd
            reg_idx_e    ridx;
            logic [15:0] rd_val;
            logic [15:0] rd_reg;

            assign ridx = decode_reg(addr[gi]);

            // Samples pre-write state, so a same-cycle write is not visible yet
            always_comb begin
                case (ridx)
                    REG_SW:   rd_val = 16'(sw_sync_reg);
                    REG_LEDR: rd_val = 16'(ledr_reg);
                    REG_HEX:  rd_val = hex_reg;
                    REG_CYC:  rd_val = 16'(cyc_reg);
                    REG_CONF: rd_val = conf_reg;
                    default:  rd_val = '0;
                endcase
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) rd_reg <= '0;
                else     rd_reg <= rd_val;
            end

            assign rd_data[gi] = rd_reg;
        end
    endgenerate

    assign ledr = ledr_reg;
    assign hex  = hex_reg;

endmodule

// File: rtl/dm_mmio_responder.sv
// Steers both CPU data-memory ports to the shared dual-port RAM or the MMIO bank
// and returns read data with the RAM's one-cycle latency.
module dm_mmio_responder
    import dm_mmio_pkg::*;
#(
    parameter int CYC_W = 16,
    parameter int SW_W  = 10,
    parameter int LED_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [8:0]       p0_DM_maddr,
    input  logic [15:0]      p0_DM_wdata,
    input  logic             p0_DM_write_mem,
    output logic [15:0]      p0_DM_rdata,
    input  logic [8:0]       p1_DM_maddr,
    input  logic [15:0]      p1_DM_wdata,
    input  logic             p1_DM_write_mem,
    output logic [15:0]      p1_DM_rdata,
    output logic [7:0]       ram_addr_a,
    output logic [7:0]       ram_addr_b,
    output logic [15:0]      ram_data_a,
    output logic [15:0]      ram_data_b,
    output logic             ram_we_a,
    output logic             ram_we_b,
    input  logic [15:0]      ram_q_a,
    input  logic [15:0]      ram_q_b,
    input  logic [SW_W-1:0]  sw_in,
    output logic [LED_W-1:0] ledr_out,
    output logic [15:0]      hex_value
);

    logic        same_addr;
    logic        sel0_reg, sel1_reg;
    logic [15:0] mmio_rd [2];

    assign same_addr  = (p0_DM_maddr == p1_DM_maddr);
    assign ram_addr_a = p0_DM_maddr[7:0];
    assign ram_addr_b = p1_DM_maddr[7:0];
    assign ram_data_a = p0_DM_wdata;
    assign ram_data_b = p1_DM_wdata;
    assign ram_we_b   = p1_DM_write_mem & ~p1_DM_maddr[MMIO_BASE_BIT];
    // Drop the p0 write when p1 writes the same word this cycle
    assign ram_we_a   = p0_DM_write_mem & ~p0_DM_maddr[MMIO_BASE_BIT]
                      & ~(p1_DM_write_mem & same_addr);

    mmio_regfile #(
        .CYC_W (CYC_W),
        .SW_W  (SW_W),
        .LED_W (LED_W)
    ) u_regfile (
        .clk     (clk),
        .rst     (rst),
        .maddr0  (p0_DM_maddr),
        .wdata0  (p0_DM_wdata),
        .write0  (p0_DM_write_mem),
        .maddr1  (p1_DM_maddr),
        .wdata1  (p1_DM_wdata),
        .write1  (p1_DM_write_mem),
        .sw_in   (sw_in),
        .ledr    (ledr_out),
        .hex     (hex_value),
        .rd_data (mmio_rd)
    );

    // Select flops reset to MMIO so rdata reads zero straight out of reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sel0_reg <= 1'b1;
            sel1_reg <= 1'b1;
        end else begin
            sel0_reg <= p0_DM_maddr[MMIO_BASE_BIT];
            sel1_reg <= p1_DM_maddr[MMIO_BASE_BIT];
        end
    end

    assign p0_DM_rdata = sel0_reg ? mmio_rd[0] : ram_q_a;
    assign p1_DM_rdata = sel1_reg ? mmio_rd[1] : ram_q_b;

endmodule
